// File: rtl/data_mem.sv
`default_nettype none
// ============================================================================
// Module   : data_mem
// Purpose  : Data-side responder: word RAM, byte-serial console FIFO and a
//            64-bit cycle timer with a shadowed high word.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem #(
  parameter int unsigned DEPTH_WORDS  = 16384,
  parameter logic [31:0] RAM_BASE     = 32'h8000_0000,
  parameter int unsigned FIFO_DEPTH   = 8,
  // Timer value loaded by reset; nonzero only for bring-up near a carry.
  parameter logic [63:0] TIMER_PRESET = 64'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dram_en,
  input  logic        dram_wen,
  input  logic [31:0] dram_addr,
  input  logic [31:0] dram_wdata,
  input  logic [3:0]  dram_wmask,
  output logic [31:0] dram_rdata,
  output logic        con_valid,
  output logic [7:0]  con_data,
  input  logic        con_ready,
  output logic        access_fault
);

  localparam int C_RAM_AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int C_PTR_W  = $clog2(FIFO_DEPTH);
  localparam int C_CNT_W  = C_PTR_W + 1;

  localparam logic [31:0]        C_DEPTH_W        = 32'(DEPTH_WORDS);
  localparam logic [C_CNT_W-1:0] C_FIFO_FULL      = C_CNT_W'(FIFO_DEPTH);
  localparam logic [31:0]        C_RAM_BASE_ADDR  = RAM_BASE;
  localparam logic [31:0]        C_CON_DATA_ADDR  = 32'hA000_03F8;
  localparam logic [31:0]        C_CON_STAT_ADDR  = 32'hA000_03FC;
  localparam logic [31:0]        C_TIMER_LO_ADDR  = 32'hA000_0048;
  localparam logic [31:0]        C_TIMER_HI_ADDR  = 32'hA000_004C;

  // --------------------------------------------------------------------------
  // Address decode (word granularity)
  // --------------------------------------------------------------------------
  logic [29:0]         word_addr;
  logic [29:0]         ram_off;
  logic [C_RAM_AW-1:0] ram_idx;
  logic                hit_ram;
  logic                hit_cdata;
  logic                hit_cstat;
  logic                hit_tlo;
  logic                hit_thi;
  logic                hit_any;
  logic                unused_addr_bits;

  assign unused_addr_bits = ^dram_addr[1:0];
  assign word_addr = dram_addr[31:2];
  assign ram_off   = word_addr - C_RAM_BASE_ADDR[31:2];
  assign ram_idx   = ram_off[C_RAM_AW-1:0];
  assign hit_ram   = (word_addr >= C_RAM_BASE_ADDR[31:2]) && ({2'b00, ram_off} < C_DEPTH_W);
  assign hit_cdata = (word_addr == C_CON_DATA_ADDR[31:2]);
  assign hit_cstat = (word_addr == C_CON_STAT_ADDR[31:2]);
  assign hit_tlo   = (word_addr == C_TIMER_LO_ADDR[31:2]);
  assign hit_thi   = (word_addr == C_TIMER_HI_ADDR[31:2]);
  assign hit_any   = hit_ram | hit_cdata | hit_cstat | hit_tlo | hit_thi;

  logic rd_req;
  logic wr_req;

  assign rd_req = dram_en & ~dram_wen;
  assign wr_req = dram_en &  dram_wen;

  // --------------------------------------------------------------------------
  // RAM: byte-masked writes, combinational reads, contents survive reset
  // --------------------------------------------------------------------------
  logic [31:0] ram_mem [DEPTH_WORDS];
  logic        ram_we;

  assign ram_we = wr_req & hit_ram & ~rst;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (dram_wmask[b]) begin
          ram_mem[ram_idx][8*b +: 8] <= dram_wdata[8*b +: 8];
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Console FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [C_PTR_W-1:0] wptr_q, wptr_d;
  logic [C_PTR_W-1:0] rptr_q, rptr_d;
  logic [C_CNT_W-1:0] count_q, count_d;
  logic               fifo_full;
  logic               fifo_empty;
  logic               push_req;
  logic               push_acc;
  logic               pop;
  logic [3:0]         stat_cnt;

  assign fifo_full  = (count_q == C_FIFO_FULL);
  assign fifo_empty = (count_q == '0);
  assign push_req   = wr_req & hit_cdata & dram_wmask[0];
  assign pop        = ~fifo_empty & con_ready;
  // A pop in the same edge frees the slot, so a push into a full FIFO lands.
  assign push_acc   = push_req & (~fifo_full | pop);

  generate
    if (C_CNT_W >= 4) begin : g_cnt_trunc
      assign stat_cnt = count_q[3:0];
    end else begin : g_cnt_pad
      assign stat_cnt = {{(4 - C_CNT_W){1'b0}}, count_q};
    end
  endgenerate

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_acc) begin
      wptr_d = wptr_q + 1'b1;
    end
    if (pop) begin
      rptr_d = rptr_q + 1'b1;
    end
    case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_acc && !rst) begin
      fifo_mem[wptr_q] <= dram_wdata[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign con_valid = ~fifo_empty;
  assign con_data  = fifo_empty ? 8'h00 : fifo_mem[rptr_q];

  // --------------------------------------------------------------------------
  // Timer, high-word shadow and sticky fault
  // --------------------------------------------------------------------------
  logic [63:0] timer_q, timer_d;
  logic [31:0] shadow_q, shadow_d;
  logic        fault_q, fault_d;

  always_comb begin
    timer_d  = timer_q + 64'd1;
    shadow_d = shadow_q;
    fault_d  = fault_q;
    // Latching the live high word on a LO read keeps a LO-then-HI pair coherent.
    if (rd_req && hit_tlo) begin
      shadow_d = timer_q[63:32];
    end
    if (dram_en && !hit_any) begin
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q  <= TIMER_PRESET;
      shadow_q <= '0;
      fault_q  <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      shadow_q <= shadow_d;
      fault_q  <= fault_d;
    end
  end

  assign access_fault = fault_q;

  // --------------------------------------------------------------------------
  // Read mux
  // --------------------------------------------------------------------------
  always_comb begin
    dram_rdata = '0;
    if (rd_req) begin
      if (hit_ram) begin
        dram_rdata = ram_mem[ram_idx];
      end else if (hit_cstat) begin
        dram_rdata = {24'h0, stat_cnt, 2'b00, fifo_empty, fifo_full};
      end else if (hit_tlo) begin
        dram_rdata = timer_q[31:0];
      end else if (hit_thi) begin
        dram_rdata = shadow_q;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem
// Purpose  : Directed bench for data_mem with a queue/array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem;

  localparam int unsigned DEPTH      = 256;
  localparam logic [31:0] BASE       = 32'h8000_0000;
  localparam int unsigned FDEPTH     = 8;
  localparam logic [63:0] PRESET     = 64'h0000_0000_FFFF_FF00;
  localparam logic [31:0] A_CDATA    = 32'hA000_03F8;
  localparam logic [31:0] A_CSTAT    = 32'hA000_03FC;
  localparam logic [31:0] A_TLO      = 32'hA000_0048;
  localparam logic [31:0] A_THI      = 32'hA000_004C;
  localparam int K_NONE = 0, K_RAM = 1, K_CDATA = 2, K_CSTAT = 3, K_TLO = 4, K_THI = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dram_en = 1'b0;
  logic        dram_wen = 1'b0;
  logic [31:0] dram_addr = '0;
  logic [31:0] dram_wdata = '0;
  logic [3:0]  dram_wmask = '0;
  logic [31:0] dram_rdata;
  logic        con_valid;
  logic [7:0]  con_data;
  logic        con_ready = 1'b0;
  logic        access_fault;

  int checks = 0;
  int errors = 0;
  logic rst_v = 1'b1;
  logic ready_v = 1'b0;

  data_mem #(
    .DEPTH_WORDS (DEPTH),
    .RAM_BASE    (BASE),
    .FIFO_DEPTH  (FDEPTH),
    .TIMER_PRESET(PRESET)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .dram_en     (dram_en),
    .dram_wen    (dram_wen),
    .dram_addr   (dram_addr),
    .dram_wdata  (dram_wdata),
    .dram_wmask  (dram_wmask),
    .dram_rdata  (dram_rdata),
    .con_valid   (con_valid),
    .con_data    (con_data),
    .con_ready   (con_ready),
    .access_fault(access_fault)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [31:0] m_mem [int];
  logic [7:0]  m_q [$];
  logic [63:0] m_tm = '0;
  logic [31:0] m_sh = '0;
  logic        m_fault = 1'b0;
  bit          m_valid = 1'b0;

  function automatic int kind(input logic [31:0] a);
    longint unsigned w;
    w = longint'({a[31:2], 2'b00});
    if (w >= longint'(BASE) && w < longint'(BASE) + 4 * longint'(DEPTH)) return K_RAM;
    if (w == longint'(A_CDATA)) return K_CDATA;
    if (w == longint'(A_CSTAT)) return K_CSTAT;
    if (w == longint'(A_TLO))   return K_TLO;
    if (w == longint'(A_THI))   return K_THI;
    return K_NONE;
  endfunction

  function automatic int ram_index(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model_update
    int  k;
    bit  do_pop;
    bit  do_push;
    logic [31:0] w;
    if (rst) begin
      m_q.delete();
      m_tm    = PRESET;
      m_sh    = '0;
      m_fault = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      k       = kind(dram_addr);
      do_pop  = (m_q.size() > 0) && con_ready;
      do_push = 1'b0;
      if (dram_en) begin
        if (k == K_NONE) m_fault = 1'b1;
        if (!dram_wen && k == K_TLO) m_sh = m_tm[63:32];
        if (dram_wen && k == K_RAM && dram_wmask != 4'h0) begin
          if (m_mem.exists(ram_index(dram_addr)) || dram_wmask == 4'hF) begin
            w = m_mem.exists(ram_index(dram_addr)) ? m_mem[ram_index(dram_addr)] : 32'h0;
            for (int b = 0; b < 4; b++)
              if (dram_wmask[b]) w[8*b +: 8] = dram_wdata[8*b +: 8];
            m_mem[ram_index(dram_addr)] = w;
          end else begin
            m_mem.delete(ram_index(dram_addr));
          end
        end
        if (dram_wen && k == K_CDATA && dram_wmask[0]) do_push = 1'b1;
      end
      if (do_pop) void'(m_q.pop_front());
      if (do_push && m_q.size() < FDEPTH) m_q.push_back(dram_wdata[7:0]);
      m_tm = m_tm + 64'd1;
    end
  end

  always @(negedge clk) begin : compare
    int  k;
    bit  known;
    logic [31:0] e;
    logic [3:0]  cnt;
    if (m_valid) begin
      k     = kind(dram_addr);
      known = 1'b1;
      e     = '0;
      cnt   = 4'(m_q.size());
      if (dram_en && !dram_wen) begin
        case (k)
          K_RAM: begin
            if (m_mem.exists(ram_index(dram_addr))) e = m_mem[ram_index(dram_addr)];
            else known = 1'b0;
          end
          K_CSTAT: e = {24'h0, cnt, 2'b00, m_q.size() == 0, m_q.size() == FDEPTH};
          K_TLO:   e = m_tm[31:0];
          K_THI:   e = m_sh;
          default: e = '0;
        endcase
      end
      if (known) chk("model_rdata", {32'h0, dram_rdata}, {32'h0, e});
      chk("model_con_valid", {63'h0, con_valid}, {63'h0, m_q.size() > 0});
      chk("model_con_data", {56'h0, con_data}, {56'h0, (m_q.size() > 0) ? m_q[0] : 8'h00});
      chk("model_fault", {63'h0, access_fault}, {63'h0, m_fault});
    end
  end

  // ---------------- stimulus ----------------
  task automatic acc(input logic en, input logic wen, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] wm);
    @(posedge clk);
    #1;
    rst        = rst_v;
    con_ready  = ready_v;
    dram_en    = en;
    dram_wen   = wen;
    dram_addr  = a;
    dram_wdata = wd;
    dram_wmask = wm;
    @(negedge clk);
  endtask

  task automatic idle();
    acc(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input logic [31:0] a);
    acc(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    acc(1'b1, 1'b1, a, d, m);
  endtask

  logic [31:0] lo;
  logic [31:0] hi;
  logic [7:0]  exp_bytes [8];
  bit          reached;

  initial begin
    rst_v = 1'b1;
    repeat (3) idle();
    rst_v = 1'b0;

    // Post-reset state; the first cycle sees the preset timer value.
    rd(A_TLO);
    chk("reset_timer_lo", {32'h0, dram_rdata}, 64'h0000_0000_FFFF_FF00);
    chk("reset_con_valid", {63'h0, con_valid}, 64'h0);
    chk("reset_con_data", {56'h0, con_data}, 64'h0);
    chk("reset_fault", {63'h0, access_fault}, 64'h0);
    rd(A_THI);
    chk("reset_timer_hi", {32'h0, dram_rdata}, 64'h0);
    idle();
    chk("idle_rdata", {32'h0, dram_rdata}, 64'h0);

    // Timer read across the low-word carry.
    reached = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_tm[31:0] == 32'hFFFF_FFFE) begin
        reached = 1'b1;
        break;
      end
      idle();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL timer_wait: carry point not reached within budget");
    end
    rd(A_TLO);
    lo = dram_rdata;
    rd(A_THI);
    hi = dram_rdata;
    chk("timer_not_torn", {hi, lo}, 64'h0000_0000_FFFF_FFFF);
    rd(A_TLO);
    chk("timer_lo_after_carry", {32'h0, dram_rdata}, 64'h1);
    rd(A_THI);
    chk("timer_hi_after_carry", {32'h0, dram_rdata}, 64'h1);

    // RAM byte masking and range edges.
    wr(BASE, 32'hDEAD_BEEF, 4'b1111);
    rd(BASE);
    chk("ram_full_write", {32'h0, dram_rdata}, 64'hDEAD_BEEF);
    wr(BASE, 32'h0000_0012, 4'b0001);
    rd(BASE);
    chk("ram_byte_write", {32'h0, dram_rdata}, 64'hDEAD_BE12);
    wr(BASE, 32'hFFFF_FFFF, 4'b0000);
    rd(BASE);
    chk("ram_mask_zero", {32'h0, dram_rdata}, 64'hDEAD_BE12);
    rd(BASE + 32'd3);
    chk("ram_low_bits_ignored", {32'h0, dram_rdata}, 64'hDEAD_BE12);
    wr(BASE + 4 * (DEPTH - 1), 32'h1234_5678, 4'b1111);
    rd(BASE + 4 * (DEPTH - 1));
    chk("ram_last_word", {32'h0, dram_rdata}, 64'h1234_5678);

    // Console: "Hi" held, then drained.
    ready_v = 1'b0;
    wr(A_CDATA, 32'h0000_0048, 4'b0001);
    wr(A_CDATA, 32'h0000_0069, 4'b0001);
    rd(A_CSTAT);
    chk("con_stat_two", {32'h0, dram_rdata}, 64'h20);
    chk("con_head_H", {56'h0, con_data}, 64'h48);
    wr(A_CDATA, 32'h0000_0077, 4'b0010);
    rd(A_CSTAT);
    chk("con_mask0_no_push", {32'h0, dram_rdata}, 64'h20);
    ready_v = 1'b1;
    idle();
    chk("con_drain_H", {56'h0, con_data}, 64'h48);
    idle();
    chk("con_drain_i", {56'h0, con_data}, 64'h69);
    rd(A_CSTAT);
    chk("con_stat_empty", {32'h0, dram_rdata}, 64'h02);
    chk("con_valid_low", {63'h0, con_valid}, 64'h0);

    // Overflow: ninth push dropped without a fault.
    ready_v = 1'b0;
    for (int i = 0; i < 9; i++) wr(A_CDATA, 32'h10 + 32'(i), 4'b0001);
    rd(A_CSTAT);
    chk("con_stat_full", {32'h0, dram_rdata}, 64'h81);
    chk("con_full_no_fault", {63'h0, access_fault}, 64'h0);

    // Full FIFO with simultaneous push and pop.
    ready_v = 1'b1;
    wr(A_CDATA, 32'h0000_00AA, 4'b0001);
    chk("con_sim_head", {56'h0, con_data}, 64'h10);
    ready_v = 1'b0;
    rd(A_CSTAT);
    chk("con_sim_count", {32'h0, dram_rdata}, 64'h81);
    chk("con_sim_new_head", {56'h0, con_data}, 64'h11);
    for (int i = 0; i < 7; i++) exp_bytes[i] = 8'h11 + 8'(i);
    exp_bytes[7] = 8'hAA;
    ready_v = 1'b1;
    for (int i = 0; i < 8; i++) begin
      idle();
      chk("con_drain_byte", {56'h0, con_data}, {56'h0, exp_bytes[i]});
    end
    ready_v = 1'b0;
    rd(A_CSTAT);
    chk("con_stat_drained", {32'h0, dram_rdata}, 64'h02);
    rd(A_CDATA);
    chk("con_data_reads_zero", {32'h0, dram_rdata}, 64'h0);
    wr(A_CSTAT, 32'hFFFF_FFFF, 4'b1111);
    rd(A_CSTAT);
    chk("con_stat_write_ignored", {32'h0, dram_rdata}, 64'h02);
    chk("reg_write_no_fault", {63'h0, access_fault}, 64'h0);

    // One word past the RAM end is unmapped.
    rd(BASE + 4 * DEPTH);
    chk("past_end_rdata", {32'h0, dram_rdata}, 64'h0);
    chk("past_end_fault_pre", {63'h0, access_fault}, 64'h0);
    idle();
    chk("past_end_fault_set", {63'h0, access_fault}, 64'h1);
    idle();
    idle();
    chk("fault_sticky", {63'h0, access_fault}, 64'h1);

    // Accesses during reset are ignored.
    rst_v = 1'b1;
    wr(BASE, 32'h0000_0000, 4'b1111);
    wr(A_CDATA, 32'h0000_0055, 4'b0001);
    rd(32'h1000_0000);
    rst_v = 1'b0;
    rd(BASE);
    chk("reset_ram_preserved", {32'h0, dram_rdata}, 64'hDEAD_BE12);
    chk("reset_fault_clear", {63'h0, access_fault}, 64'h0);
    chk("reset_no_push", {63'h0, con_valid}, 64'h0);
    rd(32'h1000_0000);
    chk("unmapped_rdata", {32'h0, dram_rdata}, 64'h0);
    idle();
    chk("unmapped_fault", {63'h0, access_fault}, 64'h1);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
